exu_wbck: RTL and testbench
===========================

// Module: exu_wbck
// PURPOSE
//  Writeback stage downstream of the integer calculate unit. Accepts CAL results (single-cycle ALU)
//  and LSU results (load data) over val/rdy handshakes, buffers CAL results in a small FIFO, and
//  arbitrates one registered regfile write per cycle. LSU has priority; a starvation counter
//  guarantees CAL progress.
// PARAMETERS
//  XLEN        32  data width of results and regfile write data
//  RIDX_W      5   regfile index width
//  FIFO_DEPTH  2   CAL result FIFO entries (power of two, >=2)
//  STARVE_MAX  3   consecutive LSU wins tolerated while the CAL FIFO is non-empty
// PORTS
//  clk            in   1       core clock
//  rst_n          in   1       asynchronous active-low reset
//  hs_cal4wb_val  in   1       CAL result valid
//  hs_wb4cal_rdy  out  1       CAL result accepted when val&rdy
//  cal_res        in   XLEN    CAL result data
//  cal_rd         in   RIDX_W  CAL destination register
//  cal_rdwen      in   1       CAL result writes the regfile
//  hs_lsu4wb_val  in   1       LSU result valid
//  hs_wb4lsu_rdy  out  1       LSU result accepted when val&rdy
//  lsu_res        in   XLEN    LSU load data
//  lsu_rd         in   RIDX_W  LSU destination register
//  o_rf_wen       out  1       regfile write enable (registered)
//  o_rf_widx      out  RIDX_W  regfile write index (registered)
//  o_rf_wdat      out  XLEN    regfile write data (registered)
//  o_wb_idle      out  1       FIFO empty and no write in flight
// BEHAVIOUR
//  - Reset (async, rst_n=0): FIFO empty, rd/wr pointers 0, starve counter 0, o_rf_wen=0,
//    o_rf_widx=0, o_rf_wdat=0, o_wb_idle=1. Reset mid-transfer drops all buffered results.
//  - hs_wb4cal_rdy = ~fifo_full (no same-cycle full pass-through). hs_wb4cal_rdy=1 out of reset.
//  - CAL beat with cal_rdwen=0 or cal_rd=0: handshaken, discarded, never occupies a slot.
//  - Selection each cycle (combinational, write registered next edge => latency 1 cycle):
//      cal_src = FIFO head if non-empty, else accepted input beat (bypass, empty FIFO only).
//      starve  = (starve_cnt == STARVE_MAX) & cal_src valid.
//      hs_wb4lsu_rdy = ~starve.  LSU wins if hs_lsu4wb_val & ~starve; else cal_src wins.
//  - LSU beat with lsu_rd=0: handshaken, no write (o_rf_wen=0), still counts as an LSU win.
//  - Bypassed CAL beat that loses to LSU is enqueued; FIFO head popped only when it wins.
//  - Enqueue and dequeue in the same cycle allowed when not full; occupancy unchanged.
//  - Pointers are log2(FIFO_DEPTH)+1 bits, wrap naturally; full = MSBs differ, low bits equal.
//  - starve_cnt: +1 (saturating at STARVE_MAX) when LSU wins while cal_src valid; cleared when
//    CAL wins or cal_src invalid.
//  - Order: CAL results written in acceptance order; no ordering between CAL and LSU.
//  - o_wb_idle = fifo_empty & ~o_rf_wen.
// CONFIGURATION
//  CIRNO_WBCK_FWD_EN defined: adds ports fwd_idx(in, RIDX_W), o_fwd_hit(out,1), o_fwd_dat(out,
//    XLEN). Combinational search of write register then FIFO entries, newest match wins; idx 0
//    never hits. Lets the decode stage bypass pending writes.
//  Undefined: forwarding ports and search logic absent; downstream stalls on o_wb_idle instead.
// STRUCTURE
//  - cirno9_define.v: CIRNO_XLEN, CIRNO_RIDX_W, CIRNO_WBCK_FIFO_DEPTH, CIRNO_WBCK_STARVE_MAX,
//    and the packed CAL entry field ranges (CIRNO_WBCK_ENT_DAT/IDX).
//  - Sub-module exu_wbck_fifo: synchronous FIFO (push/pop/full/empty/head, entry array exposed
//    for forwarding). Arbitration, starve counter and write register live in exu_wbck.
// TESTING
//  1 Reset, single CAL beat res=0x1234, rd=5 -> next cycle o_rf_wen=1, widx=5, wdat=0x1234;
//    FIFO stays empty (bypass).
//  2 LSU valid every cycle, 3 CAL beats rd=1..3 -> LSU writes for 3 cycles, 4th cycle CAL rd=1
//    wins, hs_wb4lsu_rdy=0 that cycle; all CAL writes in order 1,2,3.
//  3 Hold LSU valid, push CAL beats until FIFO_DEPTH(2) stored -> hs_wb4cal_rdy=0; pop frees
//    one slot -> rdy=1 next cycle.
//  4 CAL beat rd=0 and beat with cal_rdwen=0 -> handshaken, no o_rf_wen, FIFO occupancy 0.
//  5 Fill FIFO, assert rst_n=0 mid-stream -> immediately o_rf_wen=0, FIFO empty, o_wb_idle=1.
//  6 (FWD_EN) FIFO holds rd=7=0xA then rd=7=0xB, fwd_idx=7 -> o_fwd_hit=1, o_fwd_dat=0xB.

Source files
------------

// File: rtl/exu_wbck_pkg.sv
// Shared configuration for the writeback stage: default widths, CAL FIFO
// depth, starvation limit and the write-source selector type.
package exu_wbck_pkg;

    localparam int CIRNO_XLEN            = 32;
    localparam int CIRNO_RIDX_W          = 5;
    localparam int CIRNO_WBCK_FIFO_DEPTH = 2;
    localparam int CIRNO_WBCK_STARVE_MAX = 3;

    // Which producer owns the regfile write port this cycle.
    typedef enum logic [1:0] {
        WB_SRC_NONE = 2'd0,
        WB_SRC_LSU  = 2'd1,
        WB_SRC_CAL  = 2'd2
    } wb_src_e;

endpackage

// File: rtl/exu_wbck_fifo.sv
// Synchronous FIFO holding pending CAL results ({idx, dat} entries).
// Pointers carry one extra wrap bit so full/empty need no separate counter.
// With CIRNO_WBCK_FWD_EN defined the entry array, head position and
// occupancy are exported for the forwarding search.
module exu_wbck_fifo
    import exu_wbck_pkg::*;
#(
    parameter int W     = CIRNO_RIDX_W + CIRNO_XLEN,
    parameter int DEPTH = CIRNO_WBCK_FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [W-1:0]     din,
    input  logic             pop,
`ifdef CIRNO_WBCK_FWD_EN
    output logic [W-1:0]     ents [DEPTH],
    output logic [$clog2(DEPTH)-1:0] head_pos,
    output logic [$clog2(DEPTH):0]   count,
`endif
    output logic             full,
    output logic             empty,
    output logic [W-1:0]     head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr_r;
    logic [AW:0]  rd_ptr_r;
    logic [W-1:0] mem_r [DEPTH];

    // Pointer update; both may advance in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (push && !full) begin
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop && !empty) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

    // Entry storage, cleared on reset so forwarding never sees stale data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {W{1'b0}};
            end
        end else if (push && !full) begin
            mem_r[wr_ptr_r[AW-1:0]] <= din;
        end else begin
            mem_r[wr_ptr_r[AW-1:0]] <= mem_r[wr_ptr_r[AW-1:0]];
        end
    end

    assign empty = (wr_ptr_r == rd_ptr_r);
    assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                   (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign head  = mem_r[rd_ptr_r[AW-1:0]];

`ifdef CIRNO_WBCK_FWD_EN
    assign ents     = mem_r;
    assign head_pos = rd_ptr_r[AW-1:0];
    assign count    = wr_ptr_r - rd_ptr_r;
`endif

endmodule

// File: rtl/exu_wbck.sv
// Writeback stage: buffers CAL results, arbitrates LSU vs CAL for one
// registered regfile write per cycle (LSU priority, starvation-limited).
// Optional feature macro: CIRNO_WBCK_FWD_EN adds a forwarding search port.
module exu_wbck
    import exu_wbck_pkg::*;
#(
    parameter int XLEN       = CIRNO_XLEN,
    parameter int RIDX_W     = CIRNO_RIDX_W,
    parameter int FIFO_DEPTH = CIRNO_WBCK_FIFO_DEPTH,
    parameter int STARVE_MAX = CIRNO_WBCK_STARVE_MAX
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hs_cal4wb_val,
    output logic              hs_wb4cal_rdy,
    input  logic [XLEN-1:0]   cal_res,
    input  logic [RIDX_W-1:0] cal_rd,
    input  logic              cal_rdwen,
    input  logic              hs_lsu4wb_val,
    output logic              hs_wb4lsu_rdy,
    input  logic [XLEN-1:0]   lsu_res,
    input  logic [RIDX_W-1:0] lsu_rd,
`ifdef CIRNO_WBCK_FWD_EN
    input  logic [RIDX_W-1:0] fwd_idx,
    output logic              o_fwd_hit,
    output logic [XLEN-1:0]   o_fwd_dat,
`endif
    output logic              o_rf_wen,
    output logic [RIDX_W-1:0] o_rf_widx,
    output logic [XLEN-1:0]   o_rf_wdat,
    output logic              o_wb_idle
);

    localparam int ENT_W = RIDX_W + XLEN;
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [ENT_W-1:0]  fifo_head_s;
    logic              fifo_push_s;
    logic              fifo_pop_s;
    logic              cal_keep_s;
    logic              cal_src_vld_s;
    logic [RIDX_W-1:0] cal_src_idx_s;
    logic [XLEN-1:0]   cal_src_dat_s;
    logic              starve_s;
    logic              lsu_win_s;
    wb_src_e           wb_src_s;
    logic [CNT_W-1:0]  starve_cnt_r;

`ifdef CIRNO_WBCK_FWD_EN
    localparam int AW = $clog2(FIFO_DEPTH);
    logic [ENT_W-1:0]  fifo_ents_s [FIFO_DEPTH];
    logic [AW-1:0]     fifo_head_pos_s;
    logic [AW:0]       fifo_count_s;
    logic              fwd_hit_s;
    logic [XLEN-1:0]   fwd_dat_s;
`endif

    exu_wbck_fifo #(
        .W     (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (fifo_push_s),
        .din      ({cal_rd, cal_res}),
        .pop      (fifo_pop_s),
`ifdef CIRNO_WBCK_FWD_EN
        .ents     (fifo_ents_s),
        .head_pos (fifo_head_pos_s),
        .count    (fifo_count_s),
`endif
        .full     (fifo_full_s),
        .empty    (fifo_empty_s),
        .head     (fifo_head_s)
    );

    // Ready only when a slot is free; a full FIFO never passes through.
    assign hs_wb4cal_rdy = ~fifo_full_s;
    // Beats that would not write the regfile are accepted and dropped.
    assign cal_keep_s    = hs_cal4wb_val & hs_wb4cal_rdy & cal_rdwen &
                           (cal_rd != {RIDX_W{1'b0}});
    assign cal_src_vld_s = ~fifo_empty_s | cal_keep_s;
    assign starve_s      = (starve_cnt_r == CNT_W'(STARVE_MAX)) & cal_src_vld_s;
    assign hs_wb4lsu_rdy = ~starve_s;
    assign lsu_win_s     = hs_lsu4wb_val & ~starve_s;

    // CAL candidate: FIFO head keeps order; the live beat bypasses only when empty.
    always_comb begin
        if (fifo_empty_s) begin
            cal_src_idx_s = cal_rd;
            cal_src_dat_s = cal_res;
        end else begin
            cal_src_idx_s = fifo_head_s[ENT_W-1:XLEN];
            cal_src_dat_s = fifo_head_s[XLEN-1:0];
        end
    end

    // Pick the write-port owner for this cycle.
    always_comb begin
        wb_src_s = WB_SRC_NONE;
        if (lsu_win_s) begin
            wb_src_s = WB_SRC_LSU;
        end else if (cal_src_vld_s) begin
            wb_src_s = WB_SRC_CAL;
        end else begin
            wb_src_s = WB_SRC_NONE;
        end
    end

    // A kept beat is stored unless it went straight out through the bypass.
    assign fifo_push_s = cal_keep_s & ~(fifo_empty_s & (wb_src_s == WB_SRC_CAL));
    assign fifo_pop_s  = ~fifo_empty_s & (wb_src_s == WB_SRC_CAL);

    // Count consecutive LSU wins that held back a pending CAL result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_r <= {CNT_W{1'b0}};
        end else if (lsu_win_s && cal_src_vld_s) begin
            if (starve_cnt_r != CNT_W'(STARVE_MAX)) begin
                starve_cnt_r <= starve_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                starve_cnt_r <= starve_cnt_r;
            end
        end else begin
            starve_cnt_r <= {CNT_W{1'b0}};
        end
    end

    // Registered regfile write port; index/data hold when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_rf_wen  <= 1'b0;
            o_rf_widx <= {RIDX_W{1'b0}};
            o_rf_wdat <= {XLEN{1'b0}};
        end else begin
            case (wb_src_s)
                WB_SRC_LSU: begin
                    o_rf_wen  <= (lsu_rd != {RIDX_W{1'b0}});
                    o_rf_widx <= lsu_rd;
                    o_rf_wdat <= lsu_res;
                end
                WB_SRC_CAL: begin
                    o_rf_wen  <= 1'b1;
                    o_rf_widx <= cal_src_idx_s;
                    o_rf_wdat <= cal_src_dat_s;
                end
                default: begin
                    o_rf_wen  <= 1'b0;
                    o_rf_widx <= o_rf_widx;
                    o_rf_wdat <= o_rf_wdat;
                end
            endcase
        end
    end

    assign o_wb_idle = fifo_empty_s & ~o_rf_wen;

`ifdef CIRNO_WBCK_FWD_EN
    // Search write register first, then FIFO oldest to newest; later hits override.
    always_comb begin
        fwd_hit_s = 1'b0;
        fwd_dat_s = {XLEN{1'b0}};
        if (o_rf_wen && (o_rf_widx == fwd_idx)) begin
            fwd_hit_s = 1'b1;
            fwd_dat_s = o_rf_wdat;
        end else begin
            fwd_hit_s = 1'b0;
        end
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (((AW+1)'(i) < fifo_count_s) &&
                (fifo_ents_s[fifo_head_pos_s + AW'(i)][ENT_W-1:XLEN] == fwd_idx)) begin
                fwd_hit_s = 1'b1;
                fwd_dat_s = fifo_ents_s[fifo_head_pos_s + AW'(i)][XLEN-1:0];
            end else begin
                fwd_hit_s = fwd_hit_s;
            end
        end
        if (fwd_idx == {RIDX_W{1'b0}}) begin
            fwd_hit_s = 1'b0;
            fwd_dat_s = {XLEN{1'b0}};
        end else begin
            fwd_hit_s = fwd_hit_s;
        end
    end

    assign o_fwd_hit = fwd_hit_s;
    assign o_fwd_dat = fwd_dat_s;
`endif

endmodule

// File: tb/tb_exu_wbck.sv
// Self-checking bench for exu_wbck: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference of the writeback rules.
module tb_exu_wbck;

    localparam int DEPTH = 2;
    localparam int SMAX  = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cv = 1'b0;
    logic        cal_rdy;
    logic [31:0] cres = 32'd0;
    logic [4:0]  crd = 5'd0;
    logic        cwen = 1'b0;
    logic        lv = 1'b0;
    logic        lsu_rdy;
    logic [31:0] lres = 32'd0;
    logic [4:0]  lrd = 5'd0;
    logic        rf_wen;
    logic [4:0]  rf_widx;
    logic [31:0] rf_wdat;
    logic        wb_idle;
`ifdef CIRNO_WBCK_FWD_EN
    logic [4:0]  fwd_idx = 5'd0;
    logic        fwd_hit;
    logic [31:0] fwd_dat;
`endif

    int n_cmp = 0;
    int n_fail = 0;

    // Reference state: pending CAL results, starve count, expected write.
    logic [36:0] mq[$];
    int          sc;
    bit          e_wen;
    logic [4:0]  e_idx;
    logic [31:0] e_dat;
    int          cal_seen[$];

    exu_wbck dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .hs_cal4wb_val (cv),
        .hs_wb4cal_rdy (cal_rdy),
        .cal_res       (cres),
        .cal_rd        (crd),
        .cal_rdwen     (cwen),
        .hs_lsu4wb_val (lv),
        .hs_wb4lsu_rdy (lsu_rdy),
        .lsu_res       (lres),
        .lsu_rd        (lrd),
`ifdef CIRNO_WBCK_FWD_EN
        .fwd_idx       (fwd_idx),
        .o_fwd_hit     (fwd_hit),
        .o_fwd_dat     (fwd_dat),
`endif
        .o_rf_wen      (rf_wen),
        .o_rf_widx     (rf_widx),
        .o_rf_wdat     (rf_wdat),
        .o_wb_idle     (wb_idle)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        sc    = 0;
        e_wen = 1'b0;
    endtask

    // One clock: check ready outputs at the falling edge, writes after the rising edge.
    task automatic cycle(output bit cal_acc);
        bit ckeep, have, starve, lwin, rdy_c;
        rdy_c = (mq.size() < DEPTH);
        @(negedge clk);
        check("cal_rdy", {63'd0, cal_rdy}, {63'd0, rdy_c});
        cal_acc = cv && rdy_c;
        ckeep   = cal_acc && cwen && (crd != 5'd0);
        have    = (mq.size() != 0) || ckeep;
        starve  = (sc == SMAX) && have;
        check("lsu_rdy", {63'd0, lsu_rdy}, {63'd0, !starve});
        lwin  = lv && !starve;
        e_wen = 1'b0;
        if (lwin) begin
            e_wen = (lrd != 5'd0);
            e_idx = lrd;
            e_dat = lres;
            if (ckeep) mq.push_back({crd, cres});
            sc = have ? ((sc < SMAX) ? sc + 1 : SMAX) : 0;
        end else if (have) begin
            if (mq.size() != 0) begin
                {e_idx, e_dat} = mq.pop_front();
                if (ckeep) mq.push_back({crd, cres});
            end else begin
                e_idx = crd;
                e_dat = cres;
            end
            e_wen = 1'b1;
            sc    = 0;
        end else begin
            sc = 0;
        end
        @(posedge clk);
        #1;
        check("rf_wen", {63'd0, rf_wen}, {63'd0, e_wen});
        if (e_wen) begin
            check("rf_widx", {59'd0, rf_widx}, {59'd0, e_idx});
            check("rf_wdat", {32'd0, rf_wdat}, {32'd0, e_dat});
        end
        check("wb_idle", {63'd0, wb_idle}, {63'd0, (mq.size() == 0) && !e_wen});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_wen", {63'd0, rf_wen}, 64'd0);
        check("rst_widx", {59'd0, rf_widx}, 64'd0);
        check("rst_wdat", {32'd0, rf_wdat}, 64'd0);
        check("rst_idle", {63'd0, wb_idle}, 64'd1);
        check("rst_cal_rdy", {63'd0, cal_rdy}, 64'd1);
        rst_n = 1'b1;
    endtask

    initial begin
        bit acc;
        int tries;

        // 1: single CAL beat bypasses to the write port one cycle later
        do_reset();
        cv = 1'b1; cres = 32'h1234; crd = 5'd5; cwen = 1'b1; lv = 1'b0;
        cycle(acc);
        check("t1_wen", {63'd0, rf_wen}, 64'd1);
        check("t1_widx", {59'd0, rf_widx}, 64'd5);
        check("t1_wdat", {32'd0, rf_wdat}, 64'h1234);
        cv = 1'b0;
        cycle(acc);
        check("t1_idle", {63'd0, wb_idle}, 64'd1);

        // 2+3: LSU every cycle, CAL beats rd=1..3 held until accepted (FIFO fills)
        lv = 1'b1; lrd = 5'd8;
        for (int k = 1; k <= 3; k++) begin
            cv = 1'b1; crd = 5'(k); cres = 32'h100 + 32'(k); cwen = 1'b1;
            lres = $urandom;
            acc = 1'b0;
            tries = 0;
            while (!acc && tries < 20) begin
                cycle(acc);
                if (rf_wen && rf_widx >= 5'd1 && rf_widx <= 5'd3) cal_seen.push_back(int'(rf_widx));
                tries++;
            end
            check("t2_accept_bound", {63'd0, acc}, 64'd1);
        end
        cv = 1'b0;
        for (int i = 0; i < 12; i++) begin
            lres = $urandom;
            cycle(acc);
            if (rf_wen && rf_widx >= 5'd1 && rf_widx <= 5'd3) cal_seen.push_back(int'(rf_widx));
        end
        check("t2_cal_count", 64'(cal_seen.size()), 64'd3);
        for (int i = 0; i < cal_seen.size(); i++) begin
            check("t2_cal_order", 64'(cal_seen[i]), 64'(i + 1));
        end
        lv = 1'b0;
        cycle(acc);

        // 4: beats that do not write are accepted and dropped
        cv = 1'b1; crd = 5'd0; cwen = 1'b1; cres = 32'hDEAD;
        cycle(acc);
        check("t4_rd0_nowen", {63'd0, rf_wen}, 64'd0);
        crd = 5'd6; cwen = 1'b0;
        cycle(acc);
        check("t4_nowen", {63'd0, rf_wen}, 64'd0);
        check("t4_idle", {63'd0, wb_idle}, 64'd1);
        cv = 1'b0;

        // 5: reset in the middle of a full FIFO drops everything immediately
        lv = 1'b1; lrd = 5'd9;
        for (int k = 0; k < 3; k++) begin
            cv = 1'b1; crd = 5'(10 + k); cwen = 1'b1; cres = $urandom;
            cycle(acc);
        end
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("t5_wen", {63'd0, rf_wen}, 64'd0);
        check("t5_idle", {63'd0, wb_idle}, 64'd1);
        check("t5_cal_rdy", {63'd0, cal_rdy}, 64'd1);
        cv = 1'b0; lv = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

`ifdef CIRNO_WBCK_FWD_EN
        // 6: newest pending write for rd=7 is forwarded
        lv = 1'b1; lrd = 5'd3;
        cv = 1'b1; crd = 5'd7; cwen = 1'b1; cres = 32'hA;
        cycle(acc);
        cres = 32'hB;
        cycle(acc);
        cv = 1'b0; lv = 1'b0;
        fwd_idx = 5'd7;
        #1;
        check("t6_fwd_hit", {63'd0, fwd_hit}, 64'd1);
        check("t6_fwd_dat", {32'd0, fwd_dat}, 64'hB);
        fwd_idx = 5'd0;
        #1;
        check("t6_fwd_idx0", {63'd0, fwd_hit}, 64'd0);
        do_reset();
`endif

        // Random traffic against the reference
        for (int i = 0; i < 400; i++) begin
            cv   = ($urandom_range(0, 3) != 0);
            crd  = 5'($urandom_range(0, 7));
            cwen = ($urandom_range(0, 7) != 0);
            cres = $urandom;
            lv   = ($urandom_range(0, 1) != 0);
            lrd  = 5'($urandom_range(0, 7));
            lres = $urandom;
            cycle(acc);
        end
        cv = 1'b0; lv = 1'b0;
        for (int i = 0; i < 4; i++) cycle(acc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
